// File: rtl/decryptor_stream_ctrl_if.sv
// Handshake and core-side bundle for the streaming decrypt controller.
// The slave modport is the controller's view; master is the environment's.
interface decryptor_stream_ctrl_if #(
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               core_start;
    logic [BLOCK_W-1:0] core_ciphertext;
    logic [KEY_W-1:0]   core_key;
    logic [BLOCK_W-1:0] core_plaintext;
    logic               core_done;

    modport slave (
        input  in_valid, in_data, out_ready,
        input  core_plaintext, core_done,
        output in_ready, out_valid, out_data,
        output core_start, core_ciphertext, core_key
    );

    modport master (
        output in_valid, in_data, out_ready,
        output core_plaintext, core_done,
        input  in_ready, out_valid, out_data,
        input  core_start, core_ciphertext, core_key
    );
endinterface

// File: rtl/decryptor_stream_ctrl.sv
// Streaming block-decrypt controller: one core job per block, ECB/CBC
// chaining, DEPTH-entry plaintext FIFO, done-timeout with sticky error.
module decryptor_stream_ctrl #(
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 128,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           key,
    input  logic                       mode,
    input  logic [BLOCK_W-1:0]         iv,
    input  logic                       iv_load,
    decryptor_stream_ctrl_if.slave     bus,
    output logic                       busy,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               run_q;
    logic [BLOCK_W-1:0] ct_q;
    logic [KEY_W-1:0]   key_q;
    logic               mode_q;
    logic [BLOCK_W-1:0] chain_q;
    logic               err_q;
    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_q;
    logic [PW-1:0]      rd_q;
    logic [CW-1:0]      cnt_q;

    logic               in_rdy;
    logic               accept;
    logic               push;
    logic               pop;
    logic               abort;
    logic [BLOCK_W-1:0] pt;

    // run_q holds input closed during reset and the first edge after release
    assign in_rdy = run_q && (state_q == IDLE) &&
                    (cnt_q < CW'(DEPTH)) && !iv_load;
    assign pop    = (cnt_q != '0) && bus.out_ready;
    assign pt     = bus.core_plaintext ^ (mode_q ? chain_q : '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        accept  = 1'b0;
        push    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_rdy && bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.core_done) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ct_q    <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            chain_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                ct_q   <= bus.in_data;
                key_q  <= key;
                mode_q <= mode;
            end
            if (state_q == IDLE && iv_load) begin
                chain_q <= iv;
                err_q   <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
            if (push) begin
                chain_q <= ct_q;
                wr_q    <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= pt;
        end
    end

    assign bus.in_ready        = in_rdy;
    assign bus.out_valid       = (cnt_q != '0);
    assign bus.out_data        = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign bus.core_start      = (state_q == START);
    assign bus.core_ciphertext = busy ? ct_q : '0;
    assign bus.core_key        = busy ? key_q : '0;

    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign fifo_count = cnt_q;
endmodule

// File: tb/tb_decryptor_stream_ctrl.sv
// Scoreboard bench for decryptor_stream_ctrl with an XOR core model
// answering 12 cycles after each start.
module tb_decryptor_stream_ctrl;
    localparam int BW      = 128;
    localparam int KW      = 128;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 12;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [KW-1:0] key = '0;
    logic          mode = 1'b0;
    logic [BW-1:0] iv = '0;
    logic          iv_load = 1'b0;
    logic          busy;
    logic          err;
    logic [CW-1:0] fifo_count;

    decryptor_stream_ctrl_if #(.BLOCK_W(BW), .KEY_W(KW)) bus ();

    decryptor_stream_ctrl #(
        .BLOCK_W(BW), .KEY_W(KW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .mode      (mode),
        .iv        (iv),
        .iv_load   (iv_load),
        .bus       (bus),
        .busy      (busy),
        .err       (err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int            m_cnt = 0;
    logic [BW-1:0] m_pt = '0;
    bit            m_en = 1'b1;

    always @(posedge clk) begin
        if (m_cnt == LAT) begin
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
        end else if (bus.core_start && m_en) begin
            m_cnt <= 1;
            m_pt  <= bus.core_ciphertext ^ bus.core_key;
        end
    end

    assign bus.core_done      = (m_cnt == LAT);
    assign bus.core_plaintext = m_pt;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_pop = 0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] chain_m = '0;
    bit            exp_done = 1'b1;
    bit            acc_s;
    bit            pop_s;
    bit            ivl_s;
    logic [BW-1:0] od_s;

    task automatic check(input string tag, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [BW-1:0] e;
        #1;
        acc_s = bus.in_valid && bus.in_ready;
        pop_s = bus.out_valid && bus.out_ready;
        ivl_s = iv_load && !busy;
        od_s  = bus.out_data;
        @(posedge clk);
        #1;
        if (ivl_s) chain_m = iv;
        if (acc_s && exp_done) begin
            e = bus.in_data ^ key ^ (mode ? chain_m : '0);
            exp_q.push_back(e);
            chain_m = bus.in_data;
        end
        if (pop_s) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", od_s, e);
                n_pop++;
            end
        end
    endtask

    task automatic offer(input logic [BW-1:0] ct, input int bound,
                         output bit ok);
        ok = 1'b0;
        bus.in_data  = ct;
        bus.in_valid = 1'b1;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            ok = acc_s;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = !busy;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = !busy;
        end
        check(tag, ok, 1);
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            ok = (exp_q.size() == 0) && !busy && !bus.out_valid;
        end
        check(tag, ok, 1);
    endtask

    task automatic pp_at_done(input logic [BW-1:0] ct, input string tag);
        bit ok;
        int c0;
        offer(ct, 5, ok);
        check({tag, "_acc"}, ok, 1);
        for (int i = 0; i < 40 && !bus.core_done; i++) step();
        check({tag, "_done"}, bus.core_done, 1);
        c0 = int'(fifo_count);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_cnt"}, fifo_count, c0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            n;
        int            p0;
        logic [BW-1:0] blk [6];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_count", fifo_count, 0);
        check("rst_start", bus.core_start, 0);
        #2 rst = 1'b1;
        step();
        check("rel_ready", bus.in_ready, 1);

        // ECB, latency and core-side hold
        key  = 128'h6d65677361797372617772746f796f75;
        mode = 1'b0;
        offer(128'h7d98af48b3c1e41cc809736f9ccf67c3, 5, ok);
        check("t1_accept", ok, 1);
        check("t1_start", bus.core_start, 1);
        check("t1_core_ct", bus.core_ciphertext,
              128'h7d98af48b3c1e41cc809736f9ccf67c3);
        check("t1_core_key", bus.core_key, key);
        step();
        check("t1_start_pulse", bus.core_start, 0);
        check("t1_ct_hold", bus.core_ciphertext,
              128'h7d98af48b3c1e41cc809736f9ccf67c3);
        n = 2;
        while (!bus.out_valid && n < 60) begin
            step();
            n++;
        end
        check("t1_latency", n, 14);
        check("t1_out", bus.out_data,
              128'h10fdc83bd2b8976ea97e011bf3b608b6);
        drain("t1_drain");
        check("t1_idle_core_ct", bus.core_ciphertext, 0);

        // CBC chain from iv, then from previous ciphertext
        mode    = 1'b1;
        iv      = 128'h1;
        iv_load = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("t2_ivload_block", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        step();
        iv_load = 1'b0;
        offer(128'h0123456789abcdef0011223344556677, 5, ok);
        wait_idle("t2_c1_idle");
        offer(128'hfedcba98765432108899aabbccddeeff, 5, ok);
        wait_idle("t2_c2_idle");
        offer(128'hdeadbeef00000000cafef00d12345678, 5, ok);
        drain("t2_drain");

        // back-pressure: 4 fit, 5th refused until space opens
        mode = 1'b0;
        bus.out_ready = 1'b0;
        p0 = n_pop;
        for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom,
                                              $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            offer(blk[i], 40, ok);
            check("t3_accept", ok, 1);
        end
        offer(blk[4], 40, ok);
        check("t3_refuse", ok, 0);
        check("t3_full", fifo_count, DEPTH);
        bus.in_valid = 1'b1;
        #1;
        check("t3_ready_low", bus.in_ready, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        offer(blk[4], 40, ok);
        check("t3_accept5", ok, 1);
        offer(blk[5], 40, ok);
        check("t3_accept6", ok, 1);
        drain("t3_drain");
        check("t3_pops", n_pop - p0, 6);

        // simultaneous push/pop at count 1 and 3, then fill to full
        bus.out_ready = 1'b0;
        offer(128'h11, 5, ok);
        wait_idle("t6_idle0");
        pp_at_done(128'h22, "t6_c1");
        offer(128'h33, 5, ok);
        wait_idle("t6_idle1");
        offer(128'h44, 5, ok);
        wait_idle("t6_idle2");
        pp_at_done(128'h55, "t6_c3");
        offer(128'h66, 5, ok);
        wait_idle("t6_idle3");
        check("t6_full", fifo_count, DEPTH);
        drain("t6_drain");

        // done-timeout: core never answers
        m_en     = 1'b0;
        exp_done = 1'b0;
        mode     = 1'b1;
        offer(128'h0badf00d, 5, ok);
        check("t4_start", bus.core_start, 1);
        step();
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
        check("t4_wait_cycles", n, TIMEOUT);
        check("t4_err", err, 1);
        check("t4_ready", bus.in_ready, 1);
        check("t4_no_push", fifo_count, 0);
        m_en     = 1'b1;
        exp_done = 1'b1;
        offer(128'h5a5a5a5a, 5, ok);
        check("t4_err_no_block", ok, 1);
        drain("t4_drain");
        check("t4_err_sticky", err, 1);
        iv_load = 1'b1;
        step();
        iv_load = 1'b0;
        check("t4_err_clear", err, 0);

        // async reset mid-WAIT with two entries queued
        mode = 1'b0;
        bus.out_ready = 1'b0;
        offer(128'haa, 5, ok);
        wait_idle("t5_idle0");
        offer(128'hbb, 5, ok);
        wait_idle("t5_idle1");
        check("t5_two", fifo_count, 2);
        offer(128'hcc, 5, ok);
        repeat (3) step();
        check("t5_in_wait", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_count", fifo_count, 0);
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_out_data", bus.out_data, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", bus.in_ready, 0);
        check("t5_core_ct", bus.core_ciphertext, 0);
        check("t5_core_key", bus.core_key, 0);
        exp_q.delete();
        chain_m = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t5_late_count", fifo_count, 0);
        check("t5_late_valid", bus.out_valid, 0);
        check("t5_late_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
